// File: rtl/driver_sout_reader.sv
// Captures the 30 driver SOUT lines during a readback shift, undoes the board pin permutation
// and streams one WORD_W-bit word per logical driver. Build option: DRV_SOUT_PARITY_EN adds rd_parity.
module driver_sout_reader #(
  parameter int WORD_W = 48,
  parameter int N_DRV  = 30
) (
  input  logic              clk_33,
  input  logic              rst,
  input  logic              start,
  input  logic              sample,
  input  logic [N_DRV-1:0]  drv_sout,
  output logic              busy,
  output logic [WORD_W-1:0] rd_data,
  output logic [4:0]        rd_idx,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic              rd_parity,
  output logic              done,
  output logic              overrun
);

  localparam int CNT_W = $clog2(WORD_W + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WORD_W - 1);
  localparam logic [4:0]       LAST_IDX = 5'(N_DRV - 1);

  // Logical driver L is wired to physical SOUT lane PERM[L].
  localparam int PERM [30] = '{4, 27, 1, 29, 6, 20, 7, 16, 13, 15,
                               0, 26, 3, 25, 11, 22, 5, 18, 14, 19,
                               9, 21, 2, 23, 8, 28, 12, 17, 10, 24};

  typedef enum logic [1:0] {IDLE, CAPTURE, DRAIN} state_e;

  state_e                         state_q;
  logic [CNT_W-1:0]               cnt_q;
  logic [N_DRV-1:0][WORD_W-1:0]   words_q, words_d;
  logic [WORD_W-1:0]              rd_data_q, rd_data_d;
  logic [4:0]                     rd_idx_q, idx_nxt;
  logic                           rd_valid_q, busy_q, done_q, overrun_q;

  assign idx_nxt = rd_idx_q + 5'd1;

  always_comb begin
    for (int l = 0; l < N_DRV; l++)
      words_d[l] = {words_q[l][WORD_W-2:0], drv_sout[PERM[l]]};
  end

  // Next rd_data value; kept separate so the parity register can track it exactly.
  always_comb begin
    rd_data_d = rd_data_q;
    if (state_q == CAPTURE && sample && cnt_q == LAST_BIT)
      rd_data_d = words_d[0];
    else if (state_q == DRAIN && rd_ready && rd_idx_q != LAST_IDX)
      rd_data_d = words_q[idx_nxt];
  end

  always_ff @(posedge clk_33) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      words_q    <= '0;
      rd_data_q  <= '0;
      rd_idx_q   <= '0;
      rd_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      rd_data_q <= rd_data_d;
      if (start && state_q != IDLE) overrun_q <= 1'b1;
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= CAPTURE;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        CAPTURE: begin
          if (sample) begin
            words_q <= words_d;
            cnt_q   <= cnt_q + 1'b1;
            if (cnt_q == LAST_BIT) begin
              state_q    <= DRAIN;
              rd_valid_q <= 1'b1;
              rd_idx_q   <= '0;
            end
          end
        end
        DRAIN: begin
          if (rd_ready) begin
            if (rd_idx_q == LAST_IDX) begin
              state_q    <= IDLE;
              rd_valid_q <= 1'b0;
              rd_idx_q   <= '0;
              busy_q     <= 1'b0;
              done_q     <= 1'b1;
            end else begin
              rd_idx_q <= idx_nxt;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef DRV_SOUT_PARITY_EN
  logic rd_parity_q;
  always_ff @(posedge clk_33) begin
    if (rst) rd_parity_q <= 1'b0;
    else     rd_parity_q <= ^rd_data_d;
  end
  assign rd_parity = rd_parity_q;
`else
  assign rd_parity = 1'b0;
`endif

  assign busy     = busy_q;
  assign rd_data  = rd_data_q;
  assign rd_idx   = rd_idx_q;
  assign rd_valid = rd_valid_q;
  assign done     = done_q;
  assign overrun  = overrun_q;

endmodule

// File: tb/tb_driver_sout_reader.sv
// Scoreboarded random bench for driver_sout_reader: stimulus pushes expected words, a monitor pops on handshakes.
module tb_driver_sout_reader;
  localparam int WORD_W = 48;
  localparam int N_DRV  = 30;
  localparam int P_TB [30] = '{4, 27, 1, 29, 6, 20, 7, 16, 13, 15,
                               0, 26, 3, 25, 11, 22, 5, 18, 14, 19,
                               9, 21, 2, 23, 8, 28, 12, 17, 10, 24};

  typedef struct {
    int                idx;
    logic [WORD_W-1:0] data;
  } exp_t;

  logic              clk_33 = 1'b0;
  logic              rst, start, sample, rd_ready;
  logic [N_DRV-1:0]  drv_sout;
  logic              busy, rd_valid, rd_parity, done, overrun;
  logic [WORD_W-1:0] rd_data;
  logic [4:0]        rd_idx;

  driver_sout_reader #(.WORD_W(WORD_W), .N_DRV(N_DRV)) dut (
    .clk_33(clk_33), .rst(rst), .start(start), .sample(sample), .drv_sout(drv_sout),
    .busy(busy), .rd_data(rd_data), .rd_idx(rd_idx), .rd_valid(rd_valid),
    .rd_ready(rd_ready), .rd_parity(rd_parity), .done(done), .overrun(overrun)
  );

  always #5 clk_33 = ~clk_33;

  exp_t              sb[$];
  int                vectors = 0;
  int                miscompares = 0;
  int                xfers = 0;
  bit                exp_overrun = 1'b0;
  logic [N_DRV-1:0]  samp [WORD_W];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk_33); #1;
  endtask

  // Monitor: pops on every accepted word, checks done placement and hold stability.
  bit                mon_done_next = 1'b0;
  bit                mon_hold = 1'b0;
  logic [WORD_W-1:0] held_data;
  logic [4:0]        held_idx;
  always @(negedge clk_33) begin
    if (rst) begin
      mon_done_next = 1'b0;
      mon_hold = 1'b0;
    end else begin
      if (mon_done_next) chk("done_pulse", 64'(done), 64'd1);
      else if (done)     chk("done_spurious", 64'(done), 64'd0);
      mon_done_next = 1'b0;
      if (mon_hold && rd_valid) begin
        chk("hold_data", 64'(rd_data), 64'(held_data));
        chk("hold_idx", 64'(rd_idx), 64'(held_idx));
      end
      mon_hold = 1'b0;
      if (rd_valid && rd_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_word", 64'(rd_idx), 64'hDEAD);
        end else begin
          exp_t e;
          logic exp_par;
          e = sb.pop_front();
`ifdef DRV_SOUT_PARITY_EN
          exp_par = ^e.data;
`else
          exp_par = 1'b0;
`endif
          chk("rd_idx", 64'(rd_idx), 64'(e.idx));
          chk("rd_data", 64'(rd_data), 64'(e.data));
          chk("rd_parity", 64'(rd_parity), 64'(exp_par));
          xfers++;
          if (e.idx == N_DRV - 1) mon_done_next = 1'b1;
        end
      end else if (rd_valid) begin
        mon_hold  = 1'b1;
        held_data = rd_data;
        held_idx  = rd_idx;
      end
    end
  end

  function automatic logic [N_DRV-1:0] pattern(input int mode, input int b);
    logic [N_DRV-1:0] v;
    v = '0;
    case (mode)
      0: v[4] = 1'b1;
      1: if (b == 0) v[24] = 1'b1;
      2: v = N_DRV'($urandom);
      3: v = (b % 2 == 0) ? '1 : '0;
      default: begin                    // logical 0 -> ...0111, logical 2 -> ...0011
        if (b >= WORD_W - 3) v[4] = 1'b1;
        if (b >= WORD_W - 2) v[1] = 1'b1;
      end
    endcase
    return v;
  endfunction

  // Reference: logical word L is the time series of physical lane P(L), first sample in the MSB.
  task automatic push_expected();
    for (int l = 0; l < N_DRV; l++) begin
      exp_t e;
      e.idx = l;
      for (int b = 0; b < WORD_W; b++) e.data[WORD_W-1-b] = samp[b][P_TB[l]];
      sb.push_back(e);
    end
  endtask

  // rmode: 0 ready held high, 1 ready pattern 1,0,0,1, 2 random ready.
  task automatic run(input int mode, input int rmode, input bit inject, input int abort_at);
    int  c;
    bit  injected;
    sample = 1'b1; drv_sout = N_DRV'($urandom); step();     // sample in IDLE is ignored
    sample = 1'b0;
    start = 1'b1; step(); start = 1'b0;
    chk("busy_after_start", 64'(busy), 64'd1);
    for (int b = 0; b < WORD_W; b++) begin
      if (b == abort_at) begin
        rst = 1'b1; step();
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_valid", 64'(rd_valid), 64'd0);
        rst = 1'b0;
        sb.delete();
        exp_overrun = 1'b0;
        return;
      end
      repeat ($urandom_range(0, 2)) begin
        sample = 1'b0; drv_sout = N_DRV'($urandom); step();
      end
      samp[b]  = pattern(mode, b);
      drv_sout = samp[b];
      sample   = 1'b1;
      start    = inject && (b == 20);
      if (start) exp_overrun = 1'b1;
      if (b == WORD_W - 1) push_expected();
      step();
      sample = 1'b0; start = 1'b0;
    end
    xfers = 0;
    injected = 1'b0;
    c = 0;
    while ((busy || sb.size() != 0) && c < 400) begin
      case (rmode)
        0: rd_ready = 1'b1;
        1: rd_ready = (c % 4 == 0) || (c % 4 == 3);
        default: rd_ready = 1'($urandom);
      endcase
      sample   = 1'($urandom);
      drv_sout = N_DRV'($urandom);
      if (inject && !injected && rd_valid && rd_idx == 5'd5) begin
        start = 1'b1; injected = 1'b1; exp_overrun = 1'b1;
      end
      step();
      start = 1'b0;
      c++;
    end
    rd_ready = 1'b0; sample = 1'b0;
    step();
    chk("drain_timeout", 64'(c < 400), 64'd1);
    chk("transfer_count", 64'(xfers), 64'(N_DRV));
    chk("overrun", 64'(overrun), 64'(exp_overrun));
    chk("idle_valid", 64'(rd_valid), 64'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; sample = 1'b0; drv_sout = '0; rd_ready = 1'b0;
    repeat (3) step();
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_valid", 64'(rd_valid), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_overrun", 64'(overrun), 64'd0);
    chk("rst_parity", 64'(rd_parity), 64'd0);
    chk("rst_data", 64'(rd_data), 64'd0);
    chk("rst_idx", 64'(rd_idx), 64'd0);
    rst = 1'b0;
    step();

    run(0, 0, 1'b0, -1);      // constant lane 4 -> logical 0 all ones
    run(1, 0, 1'b0, -1);      // walking one on lane 24 -> logical 29 MSB
    run(2, 1, 1'b0, -1);      // backpressure 1,0,0,1
    run(2, 2, 1'b1, -1);      // start during capture and drain
    run(4, 0, 1'b0, -1);      // parity words 7 and 3; overrun stays set
    run(2, 0, 1'b0, 30);      // reset mid-capture
    chk("overrun_cleared", 64'(overrun), 64'd0);
    run(3, 0, 1'b0, -1);      // alternating -> AAAA_AAAA_AAAA everywhere
    for (int i = 0; i < 3; i++) run(2, 2, 1'b0, -1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=%0t required=finish", $time);
    $fatal(1, "timeout");
  end
endmodule
